// File: rtl/seven_seg_axis_mux_if.sv
// rtl/seven_seg_axis_mux_if.sv - accelerometer data in / seven-segment display out bundle
interface seven_seg_axis_mux_if;
  logic [15:0] x_data;
  logic [15:0] y_data;
  logic [15:0] z_data;
  logic        data_valid;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  axis_sel;

  modport master (
    output x_data, y_data, z_data, data_valid,
    input  an, seg, dp, axis_sel
  );

  modport slave (
    input  x_data, y_data, z_data, data_valid,
    output an, seg, dp, axis_sel
  );
endinterface

// File: rtl/seven_seg_axis_mux.sv
// rtl/seven_seg_axis_mux.sv - scans X/Y/Z accelerometer words as 4 hex digits on a common-anode display
module seven_seg_axis_mux #(
  parameter int AXIS_HOLD = 1,
  parameter int DATA_W    = 16
) (
  input  logic               clk,
  input  logic               arstn,
  input  logic               scan_src,
  input  logic               axis_src,
  seven_seg_axis_mux_if.slave bus
);

  localparam int HOLD_N = (AXIS_HOLD < 1) ? 1 : AXIS_HOLD;
  localparam int HCW    = (HOLD_N > 1) ? $clog2(HOLD_N) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_N - 1);

  typedef enum logic [1:0] {
    AX_X = 2'd0,
    AX_Y = 2'd1,
    AX_Z = 2'd2
  } axis_t;

  logic              scan_d;
  logic              axis_d;
  logic              scan_tick;
  logic              axis_tick;
  logic [DATA_W-1:0] sh_x;
  logic [DATA_W-1:0] sh_y;
  logic [DATA_W-1:0] sh_z;
  logic [DATA_W-1:0] disp_word;
  logic [DATA_W-1:0] reload_word;
  axis_t             ax_state;
  axis_t             ax_next;
  axis_t             reload_axis;
  logic              ax_valid;
  logic [HCW-1:0]    hold_cnt;
  logic              advance;
  logic              reload;
  logic [1:0]        digit;
  logic              lit;
  logic [3:0]        nibble;
  logic [3:0]        an_r;
  logic [6:0]        seg_r;
  logic              dp_r;

  // Active-low {g,f,e,d,c,b,a} hex font.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    s = 7'h7F;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign scan_tick = scan_src & ~scan_d;
  assign axis_tick = axis_src & ~axis_d;

  always_comb begin
    ax_next  = AX_X;
    ax_valid = 1'b1;
    case (ax_state)
      AX_X:    ax_next = AX_Y;
      AX_Y:    ax_next = AX_Z;
      AX_Z:    ax_next = AX_X;
      default: begin
        ax_next  = AX_X;
        ax_valid = 1'b0;
      end
    endcase
  end

  assign advance = ax_valid && axis_tick && (hold_cnt == HOLD_LAST);

  // A frame only ever picks up a new word at its start or on an axis change.
  assign reload      = (scan_tick && (digit == 2'd3)) || advance;
  assign reload_axis = advance ? ax_next : ax_state;

  always_comb begin
    reload_word = sh_x;
    case (reload_axis)
      AX_Y:    reload_word = sh_y;
      AX_Z:    reload_word = sh_z;
      default: reload_word = sh_x;
    endcase
  end

  assign nibble = disp_word[{digit, 2'b00} +: 4];

  always_ff @(posedge clk) begin
    if (!arstn) begin
      scan_d    <= 1'b1;
      axis_d    <= 1'b1;
      sh_x      <= '0;
      sh_y      <= '0;
      sh_z      <= '0;
      ax_state  <= AX_X;
      hold_cnt  <= '0;
      digit     <= 2'd0;
      disp_word <= '0;
      lit       <= 1'b0;
      an_r      <= 4'hF;
      seg_r     <= 7'h7F;
      dp_r      <= 1'b1;
    end else begin
      scan_d <= scan_src;
      axis_d <= axis_src;

      if (bus.data_valid) begin
        sh_x <= bus.x_data;
        sh_y <= bus.y_data;
        sh_z <= bus.z_data;
      end

      if (!ax_valid) begin
        ax_state <= AX_X;
        hold_cnt <= '0;
      end else if (advance) begin
        ax_state <= ax_next;
        hold_cnt <= '0;
      end else if (axis_tick) begin
        hold_cnt <= hold_cnt + 1'b1;
      end

      if (scan_tick) begin
        digit <= digit + 2'd1;
        lit   <= 1'b1;
      end

      if (reload) begin
        disp_word <= reload_word;
      end

      // Outputs follow the registered digit/word, so they trail a tick by one clk.
      if (lit) begin
        an_r  <= ~(4'b0001 << digit);
        seg_r <= hex7(nibble);
        dp_r  <= (digit != 2'(ax_state));
      end else begin
        an_r  <= 4'hF;
        seg_r <= 7'h7F;
        dp_r  <= 1'b1;
      end
    end
  end

  assign bus.an       = an_r;
  assign bus.seg      = seg_r;
  assign bus.dp       = dp_r;
  assign bus.axis_sel = 2'(ax_state);

endmodule

// File: tb/tb_seven_seg_axis_mux.sv
// tb/tb_seven_seg_axis_mux.sv - checks three hold settings against a frame-level display model
module tb_seven_seg_axis_mux;

  logic        clk = 1'b0;
  logic        arstn;
  logic        scan_src;
  logic        axis_src;
  logic        data_valid;
  logic [15:0] x_data;
  logic [15:0] y_data;
  logic [15:0] z_data;

  always #5 clk = ~clk;

  seven_seg_axis_mux_if if0 ();
  seven_seg_axis_mux_if if1 ();
  seven_seg_axis_mux_if if2 ();

  assign if0.x_data = x_data;  assign if0.y_data = y_data;
  assign if0.z_data = z_data;  assign if0.data_valid = data_valid;
  assign if1.x_data = x_data;  assign if1.y_data = y_data;
  assign if1.z_data = z_data;  assign if1.data_valid = data_valid;
  assign if2.x_data = x_data;  assign if2.y_data = y_data;
  assign if2.z_data = z_data;  assign if2.data_valid = data_valid;

  seven_seg_axis_mux #(.AXIS_HOLD(1), .DATA_W(16)) u_hold1 (
    .clk(clk), .arstn(arstn), .scan_src(scan_src), .axis_src(axis_src), .bus(if0)
  );
  seven_seg_axis_mux #(.AXIS_HOLD(3), .DATA_W(16)) u_hold3 (
    .clk(clk), .arstn(arstn), .scan_src(scan_src), .axis_src(axis_src), .bus(if1)
  );
  seven_seg_axis_mux #(.AXIS_HOLD(0), .DATA_W(16)) u_hold0 (
    .clk(clk), .arstn(arstn), .scan_src(scan_src), .axis_src(axis_src), .bus(if2)
  );

  logic [3:0] o_an  [3];
  logic [6:0] o_seg [3];
  logic       o_dp  [3];
  logic [1:0] o_ax  [3];
  assign o_an[0] = if0.an;  assign o_seg[0] = if0.seg;  assign o_dp[0] = if0.dp;  assign o_ax[0] = if0.axis_sel;
  assign o_an[1] = if1.an;  assign o_seg[1] = if1.seg;  assign o_dp[1] = if1.dp;  assign o_ax[1] = if1.axis_sel;
  assign o_an[2] = if2.an;  assign o_seg[2] = if2.seg;  assign o_dp[2] = if2.dp;  assign o_ax[2] = if2.axis_sel;

  localparam logic [6:0] FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  int n_pass = 0;
  int n_chk  = 0;

  // Model: one digit position and lit flag shared by all units, per-unit axis/hold/frame word.
  int          hold_n [3] = '{1, 3, 1};
  int          m_hold [3];
  int          m_axis [3];
  logic [15:0] m_word [3];
  logic [15:0] m_sh   [3];
  int          m_digit;
  bit          m_lit;
  bit          p_scan;
  bit          p_axis;
  logic [3:0]  e_an   [3];
  logic [6:0]  e_seg  [3];
  logic        e_dp   [3];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_edge();
    bit st, at, adv;
    int idx;
    if (!arstn) begin
      for (int i = 0; i < 3; i++) begin
        m_hold[i] = 0; m_axis[i] = 0; m_word[i] = '0; m_sh[i] = '0;
        e_an[i] = 4'hF; e_seg[i] = 7'h7F; e_dp[i] = 1'b1;
      end
      m_digit = 0; m_lit = 0; p_scan = 1; p_axis = 1;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (m_lit) begin
          idx      = int'((m_word[i] >> (4 * m_digit)) & 16'hF);
          e_an[i]  = 4'hF ^ (4'h1 << m_digit);
          e_seg[i] = FONT[idx];
          e_dp[i]  = (m_digit != m_axis[i]);
        end else begin
          e_an[i] = 4'hF; e_seg[i] = 7'h7F; e_dp[i] = 1'b1;
        end
      end
      st = scan_src && !p_scan;
      at = axis_src && !p_axis;
      for (int i = 0; i < 3; i++) begin
        adv = at && (m_hold[i] == hold_n[i] - 1);
        if (at) m_hold[i] = adv ? 0 : m_hold[i] + 1;
        if (adv) m_axis[i] = (m_axis[i] + 1) % 3;
        if ((st && m_digit == 3) || adv) m_word[i] = m_sh[m_axis[i]];
      end
      if (st) begin
        m_digit = (m_digit + 1) % 4;
        m_lit   = 1;
      end
      if (data_valid) begin
        m_sh[0] = x_data; m_sh[1] = y_data; m_sh[2] = z_data;
      end
      p_scan = scan_src;
      p_axis = axis_src;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("an[%0d]", i),   16'(o_an[i]),  16'(e_an[i]));
      chk($sformatf("seg[%0d]", i),  16'(o_seg[i]), 16'(e_seg[i]));
      chk($sformatf("dp[%0d]", i),   16'(o_dp[i]),  16'(e_dp[i]));
      chk($sformatf("axis[%0d]", i), 16'(o_ax[i]),  16'(m_axis[i]));
    end
  endtask

  task automatic scan_pulse();
    scan_src = 1'b1; repeat (3) tick();
    scan_src = 1'b0; repeat (3) tick();
  endtask

  task automatic axis_pulse();
    axis_src = 1'b1; repeat (2) tick();
    axis_src = 1'b0; repeat (2) tick();
  endtask

  task automatic load(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    x_data = x; y_data = y; z_data = z;
    data_valid = 1'b1; tick();
    data_valid = 1'b0; tick();
  endtask

  initial begin
    arstn = 1'b0; scan_src = 1'b1; axis_src = 1'b1; data_valid = 1'b0;
    x_data = '0; y_data = '0; z_data = '0;

    // Reset with both sources already high: no tick on release.
    repeat (3) tick();
    arstn = 1'b1;
    repeat (6) tick();
    chk("dark_an", 16'(if0.an), 16'hF);
    chk("dark_seg", 16'(if0.seg), 16'h7F);
    scan_src = 1'b0; axis_src = 1'b0;
    repeat (2) tick();

    // 0x1234 appears from the frame after the first wrap.
    load(16'h1234, 16'h5678, 16'h9ABC);
    repeat (4) scan_pulse();
    chk("d0_an", 16'(if0.an), 16'hE);  chk("d0_seg", 16'(if0.seg), 16'h19);
    scan_pulse();
    chk("d1_an", 16'(if0.an), 16'hD);  chk("d1_seg", 16'(if0.seg), 16'h30);
    scan_pulse();
    chk("d2_an", 16'(if0.an), 16'hB);  chk("d2_seg", 16'(if0.seg), 16'h24);
    scan_pulse();
    chk("d3_an", 16'(if0.an), 16'h7);  chk("d3_seg", 16'(if0.seg), 16'h79);

    // Axis rotation across all three hold settings.
    load(16'hAAAA, 16'h8888, 16'hFFFF);
    repeat (4) scan_pulse();
    for (int k = 1; k <= 6; k++) begin
      axis_pulse();
      chk("rot_axis1", 16'(if0.axis_sel), 16'(k % 3));
      chk("rot_axis3", 16'(if1.axis_sel), 16'((k / 3) % 3));
      repeat (4) scan_pulse();
    end

    // New data mid-frame at digit 1 waits for the next frame.
    while (m_digit != 1) scan_pulse();
    load(16'h00FF, 16'h0F0F, 16'hF00F);
    repeat (8) scan_pulse();

    // Coincident scan and axis ticks at digit 3, then reset at digit 2.
    while (m_digit != 3) scan_pulse();
    scan_src = 1'b1; axis_src = 1'b1;
    repeat (3) tick();
    scan_src = 1'b0; axis_src = 1'b0;
    repeat (3) tick();
    while (m_digit != 2) scan_pulse();
    arstn = 1'b0; tick();
    chk("rst_an", 16'(if0.an), 16'hF);
    chk("rst_axis", 16'(if0.axis_sel), 16'h0);
    arstn = 1'b1; repeat (3) tick();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      scan_src   = ($urandom_range(0, 3) == 0) ? ~scan_src : scan_src;
      axis_src   = ($urandom_range(0, 15) == 0) ? ~axis_src : axis_src;
      data_valid = ($urandom_range(0, 19) == 0);
      x_data     = 16'($urandom);
      y_data     = 16'($urandom);
      z_data     = 16'($urandom);
      arstn      = ($urandom_range(0, 499) != 0);
      tick();
    end
    data_valid = 1'b0;
    arstn = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
